// File: rtl/ppwm_pkg.sv
// Shared types and constants for the PPWM period scheduler.
//   sched_state_e : scheduler FSM states
//   cfg_addr_e    : host configuration register map
//   CTRL_*_BIT    : bit positions inside a CTRL write
package ppwm_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2
  } sched_state_e;

  typedef enum logic [1:0] {
    CFG_PERIOD = 2'd0,
    CFG_ENABLE = 2'd1,
    CFG_CTRL   = 2'd2,
    CFG_RSVD   = 2'd3
  } cfg_addr_e;

  localparam int unsigned CTRL_RUN_BIT  = 0;
  localparam int unsigned CTRL_STOP_BIT = 1;

endpackage

// File: rtl/ppwm_sched_if.sv
// Host configuration write channel for ppwm_sched (valid/ready handshake).
//   cfg_valid_i : write request
//   cfg_ready_o : write accepted when high together with cfg_valid_i
//   cfg_addr_i  : register address (see ppwm_pkg::cfg_addr_e)
//   cfg_data_i  : write data
interface ppwm_sched_if #(
  parameter int unsigned GLOBAL_COUNTER_WIDTH = 20
);
  logic                            cfg_valid_i;
  logic                            cfg_ready_o;
  logic [1:0]                      cfg_addr_i;
  logic [GLOBAL_COUNTER_WIDTH-1:0] cfg_data_i;

  modport master (output cfg_valid_i, cfg_addr_i, cfg_data_i, input cfg_ready_o);
  modport slave  (input cfg_valid_i, cfg_addr_i, cfg_data_i, output cfg_ready_o);
endinterface

// File: rtl/ppwm_shadow_reg.sv
// Shadow/active register pair with pending flag.
//   wr_en_i       : load wr_data_i into the shadow copy
//   direct_i      : also load the active copy in the same cycle (no pending)
//   apply_i       : period boundary; active takes the (possibly just-written) shadow
//   active_o      : registered active value
//   active_next_o : value active_o will hold after this edge
//   pending_o     : shadow holds a value not yet applied
module ppwm_shadow_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic             direct_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             apply_i,
  output logic [WIDTH-1:0] active_o,
  output logic [WIDTH-1:0] active_next_o,
  output logic             pending_o
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pending_q, pending_d;

  always_comb begin
    shadow_d  = wr_en_i ? wr_data_i : shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    // A write landing in the apply cycle is applied at once, so pending never sticks.
    if (apply_i || (wr_en_i && direct_i)) begin
      active_d = shadow_d;
    end
    if (apply_i) begin
      pending_d = 1'b0;
    end else if (wr_en_i && !direct_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= RESET_VAL;
      active_q  <= RESET_VAL;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_o      = active_q;
  assign active_next_o = active_d;
  assign pending_o     = pending_q;

endmodule

// File: rtl/ppwm_sched.sv
// Period scheduler for the PPWM channel executors: owns the global counter,
// issues per-channel period-start pulses and applies PERIOD/ENABLE changes
// only at period boundaries.
//   clk, rst         : clock, asynchronous active-high reset
//   cfg              : host config write channel (ppwm_sched_if.slave)
//   start_o          : per-channel one-cycle period-start pulse
//   global_counter_o : shared counter, 0..period_active
//   busy_o           : high in StRun or StStop
//   period_cnt_o     : completed periods, wraps
//   sync_i           : forces a boundary in StRun/StStop (only with PPWM_SYNC_IN_EN)
// Optional feature macro: PPWM_SYNC_IN_EN
module ppwm_sched
  import ppwm_pkg::*;
#(
  parameter int unsigned GLOBAL_COUNTER_WIDTH = 20,
  parameter int unsigned N_CH                 = 4,
  parameter int unsigned MIN_PERIOD           = 16,
  parameter int unsigned PCNT_WIDTH           = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  ppwm_sched_if.slave                     cfg,
`ifdef PPWM_SYNC_IN_EN
  input  logic                            sync_i,
`endif
  output logic [N_CH-1:0]                 start_o,
  output logic [GLOBAL_COUNTER_WIDTH-1:0] global_counter_o,
  output logic                            busy_o,
  output logic [PCNT_WIDTH-1:0]           period_cnt_o
);

  localparam int unsigned GCW = GLOBAL_COUNTER_WIDTH;
  localparam logic [GCW-1:0] MIN_P = GCW'(MIN_PERIOD);

  sched_state_e state_q, state_d;
  logic [GCW-1:0]        cnt_q, cnt_d;
  logic [N_CH-1:0]       start_q, start_d;
  logic [PCNT_WIDTH-1:0] pcnt_q, pcnt_d;

  logic [GCW-1:0]  per_active, per_next, per_wdata;
  logic [N_CH-1:0] en_active, en_next;
  logic            per_pend, en_pend;
  logic            cfg_ready, wr_acc, per_wr, en_wr, run_req, stop_req;
  logic            idle, boundary, force_bnd;
  cfg_addr_e       addr;

  assign addr      = cfg_addr_e'(cfg.cfg_addr_i);
  assign cfg_ready = !(per_pend || en_pend);
  assign cfg.cfg_ready_o = cfg_ready;
  assign wr_acc    = cfg.cfg_valid_i && cfg_ready;
  assign per_wr    = wr_acc && (addr == CFG_PERIOD);
  assign en_wr     = wr_acc && (addr == CFG_ENABLE);
  // Stop wins when both CTRL bits are set.
  assign stop_req  = wr_acc && (addr == CFG_CTRL) && cfg.cfg_data_i[CTRL_STOP_BIT];
  assign run_req   = wr_acc && (addr == CFG_CTRL) && cfg.cfg_data_i[CTRL_RUN_BIT] && !stop_req;
  assign per_wdata = (cfg.cfg_data_i < MIN_P) ? MIN_P : cfg.cfg_data_i;

`ifdef PPWM_SYNC_IN_EN
  assign force_bnd = sync_i;
`else
  assign force_bnd = 1'b0;
`endif

  assign idle     = (state_q == StIdle);
  assign boundary = !idle && ((cnt_q == per_active) || force_bnd);

  ppwm_shadow_reg #(.WIDTH(GCW), .RESET_VAL(MIN_P)) u_period (
    .clk(clk), .rst(rst), .wr_en_i(per_wr), .direct_i(idle), .wr_data_i(per_wdata),
    .apply_i(boundary), .active_o(per_active), .active_next_o(per_next), .pending_o(per_pend)
  );

  ppwm_shadow_reg #(.WIDTH(N_CH), .RESET_VAL('0)) u_enable (
    .clk(clk), .rst(rst), .wr_en_i(en_wr), .direct_i(idle), .wr_data_i(cfg.cfg_data_i[N_CH-1:0]),
    .apply_i(boundary), .active_o(en_active), .active_next_o(en_next), .pending_o(en_pend)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (run_req) state_d = StRun;
      StRun:  if (stop_req) state_d = StStop;
      StStop: begin
        if (run_req)       state_d = StRun;
        else if (boundary) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = !idle;
  end

  // Counter, period count and start pulse datapath
  always_comb begin
    cnt_d   = (idle || boundary) ? '0 : cnt_q + GCW'(1);
    pcnt_d  = boundary ? pcnt_q + PCNT_WIDTH'(1) : pcnt_q;
    start_d = '0;
    // en_next already reflects a shadow applied at this boundary.
    if ((idle && state_d == StRun) || (boundary && state_d != StIdle)) begin
      start_d = en_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pcnt_q  <= '0;
      start_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      start_q <= start_d;
    end
  end

  assign start_o          = start_q;
  assign global_counter_o = cnt_q;
  assign period_cnt_o     = pcnt_q;

  logic unused_per_next;
  assign unused_per_next = ^per_next;

endmodule

// File: tb/tb_ppwm_sched.sv
module tb_ppwm_sched;
  logic        clk;
  logic        rst;
  logic        sync_i;
  logic [3:0]  start_o;
  logic [19:0] global_counter_o;
  logic        busy_o;
  logic [7:0]  period_cnt_o;
  int checks;
  int failures;

  ppwm_sched_if #(.GLOBAL_COUNTER_WIDTH(20)) cfg_if ();

  ppwm_sched #(
    .GLOBAL_COUNTER_WIDTH(20), .N_CH(4), .MIN_PERIOD(16), .PCNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .cfg(cfg_if),
`ifdef PPWM_SYNC_IN_EN
    .sync_i(sync_i),
`endif
    .start_o(start_o), .global_counter_o(global_counter_o),
    .busy_o(busy_o), .period_cnt_o(period_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    sync_i = 1'b0;
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_addr_i = 2'd0;
    cfg_if.cfg_data_i = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Returns #1 after the edge at which the write was accepted.
  task automatic cfg_write(input logic [1:0] a, input logic [19:0] d);
    bit done;
    done = 1'b0;
    cfg_if.cfg_valid_i = 1'b1;
    cfg_if.cfg_addr_i = a;
    cfg_if.cfg_data_i = d;
    for (int i = 0; i < 200 && !done; i++) begin
      done = cfg_if.cfg_ready_o;
      step();
    end
    cfg_if.cfg_valid_i = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL cfg_write_timeout addr=%0d ready stayed 0, required accept within 200 cycles", a);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({start_o, global_counter_o, busy_o, period_cnt_o, cfg_if.cfg_ready_o} !== {4'h0, 20'h0, 1'b0, 8'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values start=%h cnt=%0d busy=%b pcnt=%0d ready=%b required 0/0/0/0/1",
               start_o, global_counter_o, busy_o, period_cnt_o, cfg_if.cfg_ready_o);
    end
  endtask

  task automatic test_basic_run();
    bit stray;
    reset_dut();
    cfg_write(2'd0, 20'd20);
    cfg_write(2'd1, 20'h5);
    cfg_write(2'd2, 20'h1);
    checks++;
    if ({start_o, global_counter_o, busy_o} !== {4'h5, 20'd0, 1'b1}) begin
      failures++;
      $display("FAIL run_entry start=%h cnt=%0d busy=%b required 5/0/1", start_o, global_counter_o, busy_o);
    end
    for (int p = 1; p <= 3; p++) begin
      stray = 1'b0;
      for (int i = 1; i <= 20; i++) begin
        step();
        if (start_o !== 4'h0 || global_counter_o !== 20'(i)) stray = 1'b1;
      end
      checks++;
      if (stray) begin
        failures++;
        $display("FAIL basic_mid_period p=%0d stray pulse or bad count, required count 1..20 with start 0", p);
      end
      step();
      checks++;
      if ({start_o, global_counter_o, period_cnt_o} !== {4'h5, 20'd0, 8'(p)}) begin
        failures++;
        $display("FAIL basic_boundary p=%0d start=%h cnt=%0d pcnt=%0d required 5/0/%0d",
                 p, start_o, global_counter_o, period_cnt_o, p);
      end
    end
  endtask

  task automatic test_period_clamp();
    reset_dut();
    cfg_write(2'd0, 20'd5);
    cfg_write(2'd1, 20'h1);
    cfg_write(2'd2, 20'h1);
    for (int i = 0; i < 16; i++) step();
    checks++;
    if ({start_o, global_counter_o} !== {4'h0, 20'd16}) begin
      failures++;
      $display("FAIL clamp_last start=%h cnt=%0d required 0/16", start_o, global_counter_o);
    end
    step();
    checks++;
    if ({start_o, global_counter_o, period_cnt_o} !== {4'h1, 20'd0, 8'd1}) begin
      failures++;
      $display("FAIL clamp_wrap start=%h cnt=%0d pcnt=%0d required 1/0/1", start_o, global_counter_o, period_cnt_o);
    end
  endtask

  task automatic test_shadow_enable();
    bit bad;
    reset_dut();
    cfg_write(2'd0, 20'd20);
    cfg_write(2'd1, 20'h5);
    cfg_write(2'd2, 20'h1);
    for (int i = 0; i < 7; i++) step();
    cfg_write(2'd1, 20'hF);
    checks++;
    if ({cfg_if.cfg_ready_o, global_counter_o} !== {1'b0, 20'd8}) begin
      failures++;
      $display("FAIL shadow_pending ready=%b cnt=%0d required 0/8", cfg_if.cfg_ready_o, global_counter_o);
    end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cfg_if.cfg_ready_o !== 1'b0 || start_o !== 4'h0) bad = 1'b1;
    end
    checks++;
    if (bad || global_counter_o !== 20'd20) begin
      failures++;
      $display("FAIL shadow_hold cnt=%0d bad=%b required cnt 20, ready 0, start 0", global_counter_o, bad);
    end
    step();
    checks++;
    if ({start_o, global_counter_o, cfg_if.cfg_ready_o} !== {4'hF, 20'd0, 1'b1}) begin
      failures++;
      $display("FAIL shadow_apply start=%h cnt=%0d ready=%b required F/0/1", start_o, global_counter_o, cfg_if.cfg_ready_o);
    end
  endtask

  task automatic test_boundary_write();
    reset_dut();
    cfg_write(2'd0, 20'd16);
    cfg_write(2'd1, 20'h5);
    cfg_write(2'd2, 20'h1);
    for (int i = 0; i < 16; i++) step();
    cfg_write(2'd1, 20'hA);
    checks++;
    if ({start_o, global_counter_o, cfg_if.cfg_ready_o} !== {4'hA, 20'd0, 1'b1}) begin
      failures++;
      $display("FAIL boundary_write start=%h cnt=%0d ready=%b required A/0/1", start_o, global_counter_o, cfg_if.cfg_ready_o);
    end
  endtask

  task automatic test_stop();
    bit bad;
    reset_dut();
    cfg_write(2'd0, 20'd20);
    cfg_write(2'd1, 20'h5);
    cfg_write(2'd2, 20'h1);
    for (int i = 0; i < 3; i++) step();
    cfg_write(2'd2, 20'h2);
    for (int i = 0; i < 16; i++) step();
    checks++;
    if ({busy_o, global_counter_o} !== {1'b1, 20'd20}) begin
      failures++;
      $display("FAIL stop_counting busy=%b cnt=%0d required 1/20", busy_o, global_counter_o);
    end
    step();
    checks++;
    if ({busy_o, global_counter_o, start_o, period_cnt_o} !== {1'b0, 20'd0, 4'h0, 8'd1}) begin
      failures++;
      $display("FAIL stop_idle busy=%b cnt=%0d start=%h pcnt=%0d required 0/0/0/1",
               busy_o, global_counter_o, start_o, period_cnt_o);
    end
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (start_o !== 4'h0 || global_counter_o !== 20'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stop_quiet activity after stop, required start 0 and cnt 0");
    end
    // Stop then run again before the boundary: period stays uninterrupted.
    cfg_write(2'd2, 20'h1);
    for (int i = 0; i < 3; i++) step();
    cfg_write(2'd2, 20'h2);
    step();
    step();
    cfg_write(2'd2, 20'h1);
    for (int i = 0; i < 13; i++) step();
    checks++;
    if ({busy_o, global_counter_o} !== {1'b1, 20'd20}) begin
      failures++;
      $display("FAIL resume_count busy=%b cnt=%0d required 1/20", busy_o, global_counter_o);
    end
    step();
    checks++;
    if ({start_o, global_counter_o, period_cnt_o, busy_o} !== {4'h5, 20'd0, 8'd2, 1'b1}) begin
      failures++;
      $display("FAIL resume_pulse start=%h cnt=%0d pcnt=%0d busy=%b required 5/0/2/1",
               start_o, global_counter_o, period_cnt_o, busy_o);
    end
  endtask

  task automatic test_ctrl_misc();
    reset_dut();
    cfg_write(2'd3, 20'hFFFFF);
    cfg_write(2'd2, 20'h3);
    cfg_write(2'd2, 20'h2);
    step();
    checks++;
    if ({busy_o, global_counter_o, start_o, cfg_if.cfg_ready_o} !== {1'b0, 20'd0, 4'h0, 1'b1}) begin
      failures++;
      $display("FAIL ctrl_misc busy=%b cnt=%0d start=%h ready=%b required 0/0/0/1",
               busy_o, global_counter_o, start_o, cfg_if.cfg_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    reset_dut();
    cfg_write(2'd0, 20'd20);
    cfg_write(2'd1, 20'h5);
    cfg_write(2'd2, 20'h1);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    #1;
    checks++;
    if ({start_o, global_counter_o, busy_o, period_cnt_o, cfg_if.cfg_ready_o} !== {4'h0, 20'h0, 1'b0, 8'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid start=%h cnt=%0d busy=%b pcnt=%0d ready=%b required 0/0/0/0/1",
               start_o, global_counter_o, busy_o, period_cnt_o, cfg_if.cfg_ready_o);
    end
    step();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (start_o !== 4'h0 || busy_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_quiet activity after reset, required start 0 and busy 0");
    end
  endtask

`ifdef PPWM_SYNC_IN_EN
  task automatic test_sync();
    reset_dut();
    cfg_write(2'd0, 20'd20);
    cfg_write(2'd1, 20'h5);
    cfg_write(2'd2, 20'h1);
    for (int i = 0; i < 9; i++) step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    checks++;
    if ({start_o, global_counter_o, period_cnt_o} !== {4'h5, 20'd0, 8'd1}) begin
      failures++;
      $display("FAIL sync_run start=%h cnt=%0d pcnt=%0d required 5/0/1", start_o, global_counter_o, period_cnt_o);
    end
    reset_dut();
    sync_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    sync_i = 1'b0;
    checks++;
    if ({start_o, global_counter_o, period_cnt_o, busy_o} !== {4'h0, 20'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL sync_idle start=%h cnt=%0d pcnt=%0d busy=%b required 0/0/0/0",
               start_o, global_counter_o, period_cnt_o, busy_o);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    sync_i = 1'b0;
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_addr_i = 2'd0;
    cfg_if.cfg_data_i = '0;
    test_reset();
    test_basic_run();
    test_period_clamp();
    test_shadow_enable();
    test_boundary_write();
    test_stop();
    test_ctrl_misc();
    test_reset_mid();
`ifdef PPWM_SYNC_IN_EN
    test_sync();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
